// File: rtl/time_set_ctrl_pkg.sv
// Shared constants, state/field encodings and field arithmetic for the time-set controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package time_set_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  // Field select codes as presented on o_field_sel
  typedef enum logic [1:0] {
    FIELD_HOUR = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2,
    FIELD_NONE = 2'd3
  } field_e;

  // Packed time word, matches the {hour, minute, second} bus layout
  typedef struct packed {
    logic [6:0] hour;
    logic [6:0] minute;
    logic [6:0] second;
  } time_t;

  localparam int         FIELD_W    = 7;
  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  // Button bit positions within i_btns
  localparam int NUM_BTNS    = 4;
  localparam int BTN_COMMIT  = 0;
  localparam int BTN_NEXT    = 1;
  localparam int BTN_INC     = 2;
  localparam int BTN_DEC     = 3;

  // Inactivity timeout
  localparam int                   TIMEOUT_W      = 15;
  localparam int                   TIMEOUT_CYCLES = 30000;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  // Blink half-period
  localparam int                 BLINK_W    = 9;
  localparam int                 BLINK_HALF = 500;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  // Out-of-range captured values are forced to zero.
  function automatic logic [FIELD_W-1:0] field_clamp(input logic [FIELD_W-1:0] v,
                                                      input logic [FIELD_W-1:0] max);
    return (v > max) ? '0 : v;
  endfunction

  // Increment/decrement with wrap; simultaneous inc+dec cancels out.
  function automatic logic [FIELD_W-1:0] field_adjust(input logic [FIELD_W-1:0] v,
                                                       input logic [FIELD_W-1:0] max,
                                                       input logic            inc,
                                                       input logic            dec);
    logic [FIELD_W-1:0] r;
    r = v;
    if (inc && !dec) begin
      r = (v >= max) ? '0 : v + FIELD_W'(1);
    end else if (dec && !inc) begin
      r = (v == '0 || v > max) ? max : v - FIELD_W'(1);
    end
    return r;
  endfunction

  function automatic logic is_edit(input state_e s);
    return (s == ST_EDIT_H) || (s == ST_EDIT_M) || (s == ST_EDIT_S);
  endfunction

  // Field rotation H -> M -> S -> H
  function automatic state_e next_field(input state_e s);
    state_e r;
    case (s)
      ST_EDIT_H: r = ST_EDIT_M;
      ST_EDIT_M: r = ST_EDIT_S;
      default:   r = ST_EDIT_H;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Rising-edge detector: turns a raw button level into a single-cycle press pulse.
// Latency: pulse_o asserts one cycle after level_i is first sampled high.
// Backpressure: none; a held level produces exactly one pulse.
// Ports: clk_1kHz/reset (sync, active-high), level_i raw button, pulse_o registered press pulse.
module btn_edge (
  input  logic clk_1kHz,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;
  logic pulse_q;

  always_ff @(posedge clk_1kHz) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_i;
      pulse_q <= level_i & ~level_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: button-driven edit of hour/minute/second with a one-shot load strobe.
// Latency: a button acts two cycles after its level rises (edge register + state update); load strobe lasts one cycle.
// Backpressure: none; o_load_sig is fire-and-forget, buttons are level inputs with edge detection.
// Ports:
//   clk_1kHz, reset      : clock and synchronous active-high reset
//   i_btns[3:0]          : commit/enter, next field, increment, decrement (bits 15:4 ignored)
//   i_current_time       : live time {hour, minute, second}, 7 bits each
//   o_load_data/_sig     : committed time and its one-cycle load strobe
//   o_edit_mode, o_field_sel, o_blink : display hints for the edit UI
module time_set_ctrl
  import time_set_ctrl_pkg::*;
(
  input  logic        clk_1kHz,
  input  logic        reset,
  input  logic [15:0] i_btns,
  input  logic [20:0] i_current_time,
  output logic [20:0] o_load_data,
  output logic        o_load_sig,
  output logic        o_edit_mode,
  output logic [1:0]  o_field_sel,
  output logic        o_blink
);

  // ---------------------------------------------------------------------------
  // Press detection
  // ---------------------------------------------------------------------------
  logic [NUM_BTNS-1:0] press;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_edge
    btn_edge u_btn_edge (
      .clk_1kHz (clk_1kHz),
      .reset    (reset),
      .level_i  (i_btns[g]),
      .pulse_o  (press[g])
    );
  end

  // Upper button bits carry nothing for this block.
  logic unused_btns;
  assign unused_btns = ^i_btns[15:NUM_BTNS];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  time_t                edit_q, edit_d;
  time_t                load_data_q, load_data_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_q, blink_d;

  time_t cur_time;
  assign cur_time = i_current_time;

  always_ff @(posedge clk_1kHz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      edit_q      <= '0;
      load_data_q <= '0;
      timeout_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      load_data_q <= load_data_d;
      timeout_q   <= timeout_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, edit registers, timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    load_data_d = load_data_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        timeout_d = '0;
        // Only enter/commit matters while idle.
        if (press[BTN_COMMIT]) begin
          edit_d.hour   = field_clamp(cur_time.hour,   HOUR_MAX);
          edit_d.minute = field_clamp(cur_time.minute, MINSEC_MAX);
          edit_d.second = field_clamp(cur_time.second, MINSEC_MAX);
          state_d       = ST_EDIT_H;
        end
      end

      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        // Priority chain: commit, then field step, then inc/dec.
        if (press[BTN_COMMIT]) begin
          state_d     = ST_COMMIT;
          load_data_d = edit_q;
          timeout_d   = '0;
        end else if (press[BTN_NEXT]) begin
          state_d   = next_field(state_q);
          timeout_d = '0;
        end else if (|press) begin
          timeout_d = '0;
          if (state_q == ST_EDIT_H) begin
            edit_d.hour = field_adjust(edit_q.hour, HOUR_MAX,
                                       press[BTN_INC], press[BTN_DEC]);
          end else if (state_q == ST_EDIT_M) begin
            edit_d.minute = field_adjust(edit_q.minute, MINSEC_MAX,
                                         press[BTN_INC], press[BTN_DEC]);
          end else begin
            edit_d.second = field_adjust(edit_q.second, MINSEC_MAX,
                                         press[BTN_INC], press[BTN_DEC]);
          end
        end else if (timeout_q == TIMEOUT_LAST) begin
          // This is the last quiet cycle allowed: abandon the edit silently.
          state_d   = ST_IDLE;
          timeout_d = '0;
        end else begin
          timeout_d = timeout_q + TIMEOUT_W'(1);
        end
      end

      ST_COMMIT: begin
        state_d   = ST_IDLE;
        timeout_d = '0;
      end

      default: begin
        state_d   = ST_IDLE;
        timeout_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Blink phase: restarts (visible) on every field change, held high outside edit
  // ---------------------------------------------------------------------------
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (is_edit(state_d) && (state_d == state_q)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  field_e field_sel;

  always_comb begin
    case (state_q)
      ST_EDIT_H: field_sel = FIELD_HOUR;
      ST_EDIT_M: field_sel = FIELD_MIN;
      ST_EDIT_S: field_sel = FIELD_SEC;
      default:   field_sel = FIELD_NONE;
    endcase
  end

  assign o_load_data = load_data_q;
  assign o_load_sig  = (state_q == ST_COMMIT);
  assign o_edit_mode = is_edit(state_q);
  assign o_field_sel = field_sel;
  assign o_blink     = blink_q;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL use one clock, clk_1kHz, input, 1 bit, with all state updated on its rising edge.
REQ-002 The block SHALL have reset, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clk_1kHz.
REQ-003 The block SHALL have i_btns, input, 16 bits, raw level buttons: [0]=edit enter/commit, [1]=next field, [2]=increment, [3]=decrement, other bits ignored.
REQ-004 The block SHALL have i_current_time, input, 21 bits, live time packed as {hour[6:0], minute[6:0], second[6:0]}.
REQ-005 The block SHALL have o_load_data, output, 21 bits, the edited time in the same packing as i_current_time.
REQ-006 The block SHALL have o_load_sig, output, 1 bit, a load strobe for the time counter.
REQ-007 The block SHALL have o_edit_mode, output, 1 bit, high while editing.
REQ-008 The block SHALL have o_field_sel, output, 2 bits, the active field: 0=hour, 1=minute, 2=second, 3=none.
REQ-009 The block SHALL have o_blink, output, 1 bit, the display blink phase for the active field.

Function
REQ-010 The block SHALL detect button presses as rising edges, registered one cycle, so a held button yields exactly one press event.
REQ-011 The state machine SHALL have the states IDLE, EDIT_H, EDIT_M, EDIT_S and COMMIT.
REQ-012 In IDLE, a btn0 press SHALL capture i_current_time into the edit registers and move to EDIT_H within the same clock edge.
REQ-013 A btn1 press SHALL step EDIT_H to EDIT_M, EDIT_M to EDIT_S, and EDIT_S back to EDIT_H.
REQ-014 In any EDIT state, a btn0 press SHALL move to COMMIT.
REQ-015 COMMIT SHALL assert o_load_sig for exactly one cycle with o_load_data valid in that same cycle, then return to IDLE.
REQ-016 An increment SHALL wrap the field at its maximum: hour 23 to 0, minute and second 59 to 0.
REQ-017 A decrement SHALL wrap the field at zero: hour 0 to 23, minute and second 0 to 59.
REQ-018 Fields SHALL be 7 bits wide, and every captured value above its field maximum SHALL be clamped to 0 on capture.
REQ-019 An increment and a decrement press in the same cycle SHALL leave the field unchanged.
REQ-020 Button priority SHALL be btn0 over btn1 over btn2/btn3, with lower-priority events in the same cycle discarded.
REQ-021 Inactivity timeout: if no press event occurs for 30000 consecutive cycles in an EDIT state, the block SHALL return to IDLE with no load strobe, discarding edits.
REQ-022 The timeout counter SHALL be 15 bits wide and clear on every press event and on entry to EDIT_H.
REQ-023 o_blink SHALL toggle every 500 cycles while in EDIT states and be held at 1 in IDLE; its phase counter SHALL restart on every field change.
REQ-024 o_edit_mode SHALL be 1 exactly in the EDIT_H, EDIT_M and EDIT_S states.
REQ-025 o_field_sel SHALL be 3 in IDLE and COMMIT.
REQ-026 o_load_data SHALL hold its last committed value outside COMMIT.
REQ-027 Every button event in IDLE other than a btn0 press SHALL be ignored.

Reset
REQ-028 Reset SHALL force: state IDLE, o_load_sig 0, o_load_data 0, o_edit_mode 0, o_field_sel 3, o_blink 1, edit registers 0, timeout and blink counters 0, edge-detector history 0.
REQ-029 Reset asserted during an EDIT state or COMMIT SHALL abort the edit without a load strobe in the following cycle.
REQ-030 Reset SHALL take priority over every button event in the same cycle.

Structure
REQ-031 State encodings, field codes, the field maxima (23, 59), the timeout (30000) and the blink half-period (500) SHALL reside in the shared constants include file.
REQ-032 Edge detection SHALL be one sub-module, btn_edge (input level, output one-cycle pulse, with clk_1kHz and reset), instantiated four times.

Verification
REQ-033 Scenario: with i_current_time = {5,30,59}, press btn0, then btn0 → o_load_sig is a single-cycle pulse with o_load_data = {5,30,59}.
REQ-034 Scenario: capture hour 23, increment once, commit → o_load_data hour = 0; capture hour 0, decrement once, commit → hour = 23.
REQ-035 Scenario: in EDIT_M with minute 59, press btn2 and btn3 in the same cycle → minute stays 59; a following btn2 press → minute = 0.
REQ-036 Scenario: enter edit, then apply no press for 30000 cycles → o_edit_mode falls to 0, o_load_sig never asserts, and o_field_sel = 3.
REQ-037 Scenario: hold btn1 for 2000 cycles from EDIT_H → exactly one step to EDIT_M (o_field_sel = 1).
REQ-038 Scenario: assert reset one cycle before COMMIT → no o_load_sig, all outputs at their reset values on the next cycle.
